// File: rtl/pu_mem_wb.sv
// Memory/writeback stage: loads, stores and RV32A atomics over a req/gnt/rvalid port,
// one access in flight, one registered writeback per instruction.
`ifndef PU_MEM_DEPTH_NBITS
`define PU_MEM_DEPTH_NBITS 16
`endif

module pu_mem_wb #(
    parameter int MEM_AW = `PU_MEM_DEPTH_NBITS
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_load,
    input  logic              ex_atomic,
    input  logic              ex_aq,
    input  logic              ex_rl,
    input  logic [4:0]        ex_funct5,
    input  logic              ex_wb_en,
    input  logic [4:0]        ex_wb_addr,
    input  logic [31:0]       ex_wb_data,
    input  logic              ex_mem_en,
    input  logic              ex_mem_wr,
    input  logic [MEM_AW-1:0] ex_mem_addr,
    input  logic [31:0]       ex_mem_wdata,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [31:0]       wb_data
);

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, AMO_WR} state_t;

    state_t state, state_nxt;

    // Ordering bits need no action with a single in-order access outstanding.
    logic unused_bits;
    assign unused_bits = ^{ex_load, ex_aq, ex_rl};

    function automatic logic [3:0] store_be(input logic word, input logic [2:0] f3,
                                            input logic [1:0] lane);
        if (word)       store_be = 4'b1111;
        else if (f3[0]) store_be = lane[1] ? 4'b1100 : 4'b0011;
        else            store_be = 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] store_data(input logic word, input logic [2:0] f3,
                                               input logic [31:0] d);
        if (word)       store_data = d;
        else if (f3[0]) store_data = {2{d[15:0]}};
        else            store_data = {4{d[7:0]}};
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] rd);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane[1] ? rd[31:16] : rd[15:0];
        b = rd[8*lane +: 8];
        if (f3[1])      load_extract = rd;
        else if (f3[0]) load_extract = {{16{h[15] & ~f3[2]}}, h};
        else            load_extract = {{24{b[7] & ~f3[2]}}, b};
    endfunction

    function automatic logic [31:0] amo_calc(input logic [4:0] f5, input logic [31:0] old,
                                             input logic [31:0] rs2);
        logic signed [31:0] old_s, rs2_s;
        old_s = old;
        rs2_s = rs2;
        case (f5)
            F5_ADD:  amo_calc = old + rs2;
            F5_XOR:  amo_calc = old ^ rs2;
            F5_AND:  amo_calc = old & rs2;
            F5_OR:   amo_calc = old | rs2;
            F5_MIN:  amo_calc = (old_s < rs2_s) ? old : rs2;
            F5_MAX:  amo_calc = (old_s > rs2_s) ? old : rs2;
            F5_MINU: amo_calc = (old < rs2) ? old : rs2;
            F5_MAXU: amo_calc = (old > rs2) ? old : rs2;
            default: amo_calc = rs2;
        endcase
    endfunction

    // Bundle fields kept for the later phases of a memory op
    logic [2:0]        funct3_p0;
    logic [4:0]        funct5_p0;
    logic [1:0]        lane_p0;
    logic [4:0]        rd_p0;
    logic              is_store_p0, is_sc_p0, is_amo_p0;
    logic [31:0]       rs2_p0, old_p0;
    logic [MEM_AW-1:0] addr_p0;

    logic ex_is_sc, ex_is_amo, ex_write, ex_word;
    assign ex_is_sc  = ex_atomic && (ex_funct5 == F5_SC);
    assign ex_is_amo = ex_atomic && (ex_funct5 != F5_SC) && (ex_funct5 != F5_LR);
    assign ex_write  = ex_atomic ? ex_is_sc : ex_mem_wr;
    assign ex_word   = ex_atomic || ex_funct3[1];
    assign ex_ready  = (state == IDLE);

    always_ff @(posedge clk) begin
        if (ex_valid && ex_ready) begin
            funct3_p0   <= ex_funct3;
            funct5_p0   <= ex_funct5;
            lane_p0     <= ex_mem_addr[1:0];
            rd_p0       <= ex_wb_addr;
            is_store_p0 <= ex_mem_wr && !ex_atomic;
            is_sc_p0    <= ex_is_sc;
            is_amo_p0   <= ex_is_amo;
            rs2_p0      <= ex_mem_wdata;
            addr_p0     <= {ex_mem_addr[MEM_AW-1:2], 2'b00};
        end
        if (state == WAIT && mem_rvalid) old_p0 <= mem_rdata;
    end

    logic              mem_req_nxt, mem_wr_nxt, wb_en_nxt;
    logic [MEM_AW-1:0] mem_addr_nxt;
    logic [3:0]        mem_be_nxt;
    logic [31:0]       mem_wdata_nxt, wb_data_nxt;
    logic [4:0]        wb_addr_nxt;

    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_wr_nxt    = mem_wr;
        mem_addr_nxt  = mem_addr;
        mem_be_nxt    = mem_be;
        mem_wdata_nxt = mem_wdata;
        wb_en_nxt     = 1'b0;
        wb_addr_nxt   = wb_addr;
        wb_data_nxt   = wb_data;
        case (state)
            IDLE: begin
                if (ex_valid && !ex_mem_en) begin
                    wb_en_nxt   = ex_wb_en && (ex_wb_addr != 5'd0);
                    wb_addr_nxt = ex_wb_addr;
                    wb_data_nxt = ex_wb_data;
                end else if (ex_valid) begin
                    state_nxt     = REQ;
                    mem_req_nxt   = 1'b1;
                    mem_wr_nxt    = ex_write;
                    mem_addr_nxt  = ex_word ? {ex_mem_addr[MEM_AW-1:2], 2'b00} : ex_mem_addr;
                    mem_be_nxt    = ex_write ? store_be(ex_word, ex_funct3, ex_mem_addr[1:0]) : 4'b0000;
                    mem_wdata_nxt = ex_write ? store_data(ex_word, ex_funct3, ex_mem_wdata) : 32'd0;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_nxt   = 1'b0;
                    mem_wr_nxt    = 1'b0;
                    mem_addr_nxt  = '0;
                    mem_be_nxt    = 4'b0000;
                    mem_wdata_nxt = 32'd0;
                    if (is_sc_p0) begin
                        wb_en_nxt   = (rd_p0 != 5'd0);
                        wb_addr_nxt = rd_p0;
                        wb_data_nxt = 32'd0;
                        state_nxt   = IDLE;
                    end else if (is_store_p0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid && is_amo_p0) begin
                    state_nxt     = AMO_WR;
                    mem_req_nxt   = 1'b1;
                    mem_wr_nxt    = 1'b1;
                    mem_addr_nxt  = addr_p0;
                    mem_be_nxt    = 4'b1111;
                    mem_wdata_nxt = amo_calc(funct5_p0, mem_rdata, rs2_p0);
                end else if (mem_rvalid) begin
                    wb_en_nxt   = (rd_p0 != 5'd0);
                    wb_addr_nxt = rd_p0;
                    wb_data_nxt = load_extract(funct3_p0, lane_p0, mem_rdata);
                    state_nxt   = IDLE;
                end
            end
            AMO_WR: begin
                if (mem_gnt) begin
                    mem_req_nxt   = 1'b0;
                    mem_wr_nxt    = 1'b0;
                    mem_addr_nxt  = '0;
                    mem_be_nxt    = 4'b0000;
                    mem_wdata_nxt = 32'd0;
                    wb_en_nxt     = (rd_p0 != 5'd0);
                    wb_addr_nxt   = rd_p0;
                    wb_data_nxt   = old_p0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'd0;
            wb_en     <= 1'b0;
            wb_addr   <= 5'd0;
            wb_data   <= 32'd0;
        end else begin
            state     <= state_nxt;
            mem_req   <= mem_req_nxt;
            mem_wr    <= mem_wr_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_be    <= mem_be_nxt;
            mem_wdata <= mem_wdata_nxt;
            wb_en     <= wb_en_nxt;
            wb_addr   <= wb_addr_nxt;
            wb_data   <= wb_data_nxt;
        end
    end

endmodule

// File: tb/tb_pu_mem_wb.sv
// Bench for pu_mem_wb: directed bundles, a memory responder that checks every request
// against an expected-request queue, and a writeback monitor fed by a scoreboard queue.
module tb_pu_mem_wb;

    localparam int AW = 16;

    logic          clk, rstn;
    logic          ex_valid, ex_ready;
    logic [2:0]    ex_funct3;
    logic          ex_load, ex_atomic, ex_aq, ex_rl;
    logic [4:0]    ex_funct5;
    logic          ex_wb_en;
    logic [4:0]    ex_wb_addr;
    logic [31:0]   ex_wb_data;
    logic          ex_mem_en, ex_mem_wr;
    logic [AW-1:0] ex_mem_addr;
    logic [31:0]   ex_mem_wdata;
    logic          mem_req, mem_gnt, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;

    pu_mem_wb #(.MEM_AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_funct3(ex_funct3), .ex_load(ex_load), .ex_atomic(ex_atomic),
        .ex_aq(ex_aq), .ex_rl(ex_rl), .ex_funct5(ex_funct5),
        .ex_wb_en(ex_wb_en), .ex_wb_addr(ex_wb_addr), .ex_wb_data(ex_wb_data),
        .ex_mem_en(ex_mem_en), .ex_mem_wr(ex_mem_wr),
        .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   data;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int          gnt_delay = 0;
    int          rv_delay  = 1;
    logic [31:0] rdata_cfg = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic exp_req(input logic wr, input logic [AW-1:0] addr, input logic [3:0] be,
                           input logic [31:0] data);
        req_t r;
        r.wr = wr; r.addr = addr; r.be = be; r.data = data;
        req_q.push_back(r);
    endtask

    task automatic exp_wb(input logic [4:0] rd, input logic [31:0] data);
        wb_t w;
        w.rd = rd; w.data = data;
        wb_q.push_back(w);
    endtask

    // Memory responder: grants after gnt_delay cycles, returns rdata_cfg rv_delay cycles later.
    initial begin : responder
        int   age;
        int   rv_cnt;
        logic just_granted;
        logic [52:0] snap;
        req_t r;
        age = 0; rv_cnt = 0; just_granted = 1'b0; snap = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata_cfg;
                end
            end
            if (just_granted) check("req_drop_after_gnt", {63'd0, mem_req}, 64'd0);
            just_granted = 1'b0;
            if (mem_req === 1'b1 && rstn) begin
                if (age == 0) snap = {mem_wr, mem_addr, mem_be, mem_wdata};
                else check("req_stable", {11'd0, mem_wr, mem_addr, mem_be, mem_wdata}, {11'd0, snap});
                if (age >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    age = 0;
                    just_granted = 1'b1;
                    if (req_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL req_unexpected: got wr=%0b addr=%h, required no request", mem_wr, mem_addr);
                    end else begin
                        r = req_q.pop_front();
                        check("req_wr", {63'd0, mem_wr}, {63'd0, r.wr});
                        check("req_addr", {48'd0, mem_addr}, {48'd0, r.addr});
                        if (r.wr) begin
                            check("req_be", {60'd0, mem_be}, {60'd0, r.be});
                            check("req_wdata", {32'd0, mem_wdata}, {32'd0, r.data});
                        end
                    end
                    if (!mem_wr) rv_cnt = rv_delay;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Writeback monitor
    initial begin : monitor
        wb_t w;
        forever begin
            @(negedge clk);
            if (wb_en === 1'b1) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_addr, wb_data);
                end else begin
                    w = wb_q.pop_front();
                    check("wb_addr", {59'd0, wb_addr}, {59'd0, w.rd});
                    check("wb_data", {32'd0, wb_data}, {32'd0, w.data});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic send(input logic men, input logic wr, input logic ld, input logic at,
                        input logic [4:0] f5, input logic [2:0] f3, input logic wbe,
                        input logic [4:0] rd, input logic [31:0] wbd,
                        input logic [AW-1:0] addr, input logic [31:0] wd);
        int guard;
        guard = 0;
        while (!ex_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_ready_timeout", 64'd0, 64'd1);
        ex_valid = 1'b1; ex_mem_en = men; ex_mem_wr = wr; ex_load = ld; ex_atomic = at;
        ex_funct5 = f5; ex_funct3 = f3; ex_wb_en = wbe; ex_wb_addr = rd; ex_wb_data = wbd;
        ex_mem_addr = addr; ex_mem_wdata = wd;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!ex_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic alu(input logic wbe, input logic [4:0] rd, input logic [31:0] d);
        send(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, wbe, rd, d, '0, 32'd0);
    endtask

    task automatic load(input logic [2:0] f3, input logic [AW-1:0] addr, input logic [4:0] rd);
        send(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, f3, 1'b1, rd, 32'd0, addr, 32'd0);
        wait_idle();
    endtask

    task automatic store(input logic [2:0] f3, input logic [AW-1:0] addr, input logic [31:0] d);
        send(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, f3, 1'b0, 5'd0, 32'd0, addr, d);
        wait_idle();
    endtask

    task automatic amo(input logic [4:0] f5, input logic [AW-1:0] addr, input logic [31:0] rs2,
                       input logic [4:0] rd);
        send(1'b1, 1'b0, 1'b0, 1'b1, f5, 3'b010, 1'b1, rd, 32'd0, addr, rs2);
        wait_idle();
    endtask

    initial begin : stim
        int guard;
        rstn = 1'b1;
        ex_valid = 1'b0; ex_funct3 = 3'd0; ex_load = 1'b0; ex_atomic = 1'b0;
        ex_aq = 1'b0; ex_rl = 1'b0; ex_funct5 = 5'd0; ex_wb_en = 1'b0;
        ex_wb_addr = 5'd0; ex_wb_data = 32'd0; ex_mem_en = 1'b0; ex_mem_wr = 1'b0;
        ex_mem_addr = '0; ex_mem_wdata = 32'd0;
        #3 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        check("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
        check("rst_mem_be", {60'd0, mem_be}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_wb_en", {63'd0, wb_en}, 64'd0);
        check("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
        check("rst_wb_data", {32'd0, wb_data}, 64'd0);
        check("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
        rstn = 1'b1;
        @(negedge clk);

        // ALU pass-through, back to back, then x0 and wb_en=0 bundles that must not write
        exp_wb(5'd5, 32'h0000_0011);
        exp_wb(5'd6, 32'h0000_0022);
        exp_wb(5'd7, 32'h0000_0033);
        check("alu_ready0", {63'd0, ex_ready}, 64'd1); alu(1'b1, 5'd5, 32'h0000_0011);
        check("alu_ready1", {63'd0, ex_ready}, 64'd1); alu(1'b1, 5'd6, 32'h0000_0022);
        check("alu_ready2", {63'd0, ex_ready}, 64'd1); alu(1'b1, 5'd7, 32'h0000_0033);
        alu(1'b1, 5'd0, 32'hDEAD_BEEF);
        alu(1'b0, 5'd8, 32'h1234_5678);
        repeat (2) @(negedge clk);

        // Loads against rdata 0x80FF1234
        rdata_cfg = 32'h80FF_1234;
        exp_req(1'b0, 16'h0103, 4'h0, 32'd0); exp_wb(5'd10, 32'hFFFF_FF80);
        load(3'b000, 16'h0103, 5'd10);
        exp_req(1'b0, 16'h0102, 4'h0, 32'd0); exp_wb(5'd11, 32'h0000_80FF);
        load(3'b101, 16'h0102, 5'd11);
        exp_req(1'b0, 16'h0101, 4'h0, 32'd0); exp_wb(5'd12, 32'h0000_1234);
        load(3'b001, 16'h0101, 5'd12);
        exp_req(1'b0, 16'h0102, 4'h0, 32'd0); exp_wb(5'd13, 32'h0000_00FF);
        load(3'b100, 16'h0102, 5'd13);
        exp_req(1'b0, 16'h0104, 4'h0, 32'd0); exp_wb(5'd14, 32'h80FF_1234);
        load(3'b010, 16'h0106, 5'd14);
        exp_req(1'b0, 16'h0100, 4'h0, 32'd0); exp_wb(5'd15, 32'h80FF_1234);
        load(3'b110, 16'h0103, 5'd15);

        // Stores: SB with a slow grant, then SH and SW
        gnt_delay = 4;
        exp_req(1'b1, 16'h0101, 4'b0010, 32'hABAB_ABAB);
        store(3'b000, 16'h0101, 32'h0000_00AB);
        gnt_delay = 0;
        exp_req(1'b1, 16'h0103, 4'b1100, 32'hCDEF_CDEF);
        store(3'b001, 16'h0103, 32'h1234_CDEF);
        exp_req(1'b1, 16'h0104, 4'b1111, 32'h0102_0304);
        store(3'b010, 16'h0107, 32'h0102_0304);

        // Atomics
        rdata_cfg = 32'hFFFF_FFFF;
        exp_req(1'b0, 16'h0040, 4'h0, 32'd0);
        exp_req(1'b1, 16'h0040, 4'b1111, 32'h0000_0000);
        exp_wb(5'd16, 32'hFFFF_FFFF);
        amo(5'b00000, 16'h0040, 32'h0000_0001, 5'd16);
        rdata_cfg = 32'h7FFF_FFFF;
        exp_req(1'b0, 16'h0044, 4'h0, 32'd0);
        exp_req(1'b1, 16'h0044, 4'b1111, 32'h7FFF_FFFF);
        exp_wb(5'd17, 32'h7FFF_FFFF);
        amo(5'b11000, 16'h0044, 32'h8000_0000, 5'd17);
        exp_req(1'b0, 16'h0044, 4'h0, 32'd0);
        exp_req(1'b1, 16'h0044, 4'b1111, 32'h8000_0000);
        exp_wb(5'd18, 32'h7FFF_FFFF);
        amo(5'b10000, 16'h0044, 32'h8000_0000, 5'd18);
        rdata_cfg = 32'hFF00_FF00;
        exp_req(1'b0, 16'h0048, 4'h0, 32'd0);
        exp_req(1'b1, 16'h0048, 4'b1111, 32'hF00F_F00F);
        exp_wb(5'd19, 32'hFF00_FF00);
        amo(5'b00100, 16'h004B, 32'h0F0F_0F0F, 5'd19);
        exp_req(1'b1, 16'h0044, 4'b1111, 32'hCAFE_BABE);
        exp_wb(5'd20, 32'h0000_0000);
        amo(5'b00011, 16'h0045, 32'hCAFE_BABE, 5'd20);
        rdata_cfg = 32'h1234_5678;
        exp_req(1'b0, 16'h0044, 4'h0, 32'd0);
        exp_wb(5'd21, 32'h1234_5678);
        amo(5'b00010, 16'h0046, 32'd0, 5'd21);

        // Reset while waiting for read data; the late rvalid must be ignored
        rv_delay = 6;
        exp_req(1'b0, 16'h0200, 4'h0, 32'd0);
        send(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'b010, 1'b1, 5'd22, 32'd0, 16'h0200, 32'd0);
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (mem_gnt !== 1'b1 && guard < 50);
        if (guard >= 50) check("rst_test_gnt_timeout", 64'd0, 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        check("midrst_wb_en", {63'd0, wb_en}, 64'd0);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        check("postrst_ready", {63'd0, ex_ready}, 64'd1);
        check("postrst_mem_req", {63'd0, mem_req}, 64'd0);
        rv_delay = 1;

        exp_wb(5'd9, 32'h0000_0099);
        alu(1'b1, 5'd9, 32'h0000_0099);
        rdata_cfg = 32'h5555_AAAA;
        exp_req(1'b0, 16'h0200, 4'h0, 32'd0); exp_wb(5'd23, 32'h5555_AAAA);
        load(3'b010, 16'h0200, 5'd23);

        guard = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        check("req_queue_drained", 64'(req_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
